imm_ext_stage: RTL and testbench
================================

// Module: imm_ext_stage
// PURPOSE
//   Registered, parametrised immediate-extension pipeline stage for the MIPS datapath.
//   Takes a raw instruction immediate plus an extension mode and produces an OUT_W-bit
//   operand one cycle later.
//   Sits between decode and execute; carries a sideband tag (e.g. destination register).
//   Uses a valid/ready handshake with a 2-entry skid buffer and a pipeline flush.
// PARAMETERS
//   IN_W       16  immediate input width
//   OUT_W      32  output operand width; must satisfy OUT_W >= IN_W + 2
//   SHAMT_LSB  6   LSB position of the shift-amount field inside the immediate
//   SHAMT_W    5   shift-amount field width; SHAMT_LSB+SHAMT_W <= IN_W
//   TAG_W      5   sideband tag width, passed through unchanged
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high reset
//   flush      in   1        kill all held and incoming entries
//   in_valid   in   1        upstream entry valid
//   in_ready   out  1        stage can accept an entry this cycle
//   in_mode    in   3        extension mode, encoded as EXTM_* values
//   in_imm     in   IN_W     raw immediate
//   in_tag     in   TAG_W    sideband tag
//   out_valid  out  1        output entry valid
//   out_ready  in   1        downstream accepts the entry this cycle
//   out_data   out  OUT_W    extended operand
//   out_tag    out  TAG_W    tag belonging to out_data
// BEHAVIOUR
//   - Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
//   - Mode encoding:
//     0 ZERO   {0, imm}
//     1 SIGN   {imm[IN_W-1] repeated, imm}
//     2 HIGH   imm placed in the top IN_W bits, low bits 0
//     3 SHIFT  zero-extended imm[SHAMT_LSB+:SHAMT_W]
//     4 BRANCH sign-extended imm shifted left by 2, truncated to OUT_W (macro only)
//     5-7      unused; treated as ZERO
//   - Handshake: an input transfer happens when in_valid && in_ready.
//     An output transfer happens when out_valid && out_ready.
//   - Storage: output register (main) plus one skid register. in_ready = !skid_valid.
//     in_ready is registered and does not depend combinationally on out_ready.
//   - Latency: 1 cycle. An entry accepted in cycle N is visible on out_* in cycle N+1
//     if main is empty or drains in cycle N.
//   - Main empty, or main draining this cycle: the accepted entry goes to main.
//   - Main full and stalled: the accepted entry goes to skid.
//   - When main drains and skid is full, skid moves to main and skid clears.
//   - Ordering is strictly FIFO. No entry is duplicated or dropped except on flush/reset.
//   - out_data/out_tag hold stable while out_valid && !out_ready.
//   - Flush: main_valid and skid_valid are 0 next cycle. An entry offered in the flush
//     cycle is discarded. Flush has priority over every transfer.
//     in_ready is 1 the cycle after a flush.
//   - Reset, including mid-transfer: out_valid=0, out_data=0, out_tag=0, skid cleared,
//     in_ready=1 in the cycle after reset is sampled. Reset has priority over flush.
//   - Simultaneous accept and drain with skid empty: main is replaced by the new entry;
//     throughput is 1 entry/cycle.
//   - Arithmetic is width-exact. BRANCH discards the top 2 bits of the sign-extended value.
//     Extension logic is combinational on the input side; only the results are stored.
// CONFIGURATION
//   - Macro: IMM_EXT_BRANCH_EN.
//   - Defined: mode 4 = BRANCH as specified above.
//   - Undefined: mode 4 behaves as ZERO and no shift logic is synthesised.
// STRUCTURE
//   - Shared header (def.v family):
//     EXTM_ZERO/SIGN/HIGH/SHIFT/BRANCH mode codes and EXTM_len = 3.
//   - Sub-module imm_ext_core: pure combinational mode -> OUT_W value, same parameters.
//   - This module instantiates imm_ext_core once, ahead of the main/skid registers.
// TESTING
//   1. SIGN, imm=16'h8001, out_ready=1 -> next cycle out_data=32'hFFFF8001, out_valid=1.
//      HIGH, imm=16'h1234 -> 32'h12340000.
//   2. SHIFT, imm=16'h07C0 -> out_data=32'h0000001F.
//      Mode 6, imm=16'hFFFF -> 32'h0000FFFF.
//   3. out_ready=0, send A(tag1) then B(tag2): in_ready falls after B.
//      C is held upstream. Raising out_ready yields A, B, C in order with no bubble
//      after the stall.
//   4. Skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1.
//      The flushed input never appears.
//   5. BRANCH, imm=16'hFFFF -> 32'hFFFFFFFC with IMM_EXT_BRANCH_EN defined,
//      32'h0000FFFF without it.
//   6. Assert reset while main and skid are full and out_ready=0 -> next cycle
//      out_valid=0, out_data=0, out_tag=0, in_ready=1.

Source files
------------

// File: rtl/imm_ext_stage_pkg.sv
// Shared immediate-extension mode codes for the decode/execute boundary.
// Latency: n/a (constants only).
// Backpressure: n/a.
package imm_ext_stage_pkg;

  // Width of the extension-mode field carried with each instruction
  localparam int EXTM_len = 3;

  localparam logic [EXTM_len-1:0] EXTM_ZERO   = 3'd0;
  localparam logic [EXTM_len-1:0] EXTM_SIGN   = 3'd1;
  localparam logic [EXTM_len-1:0] EXTM_HIGH   = 3'd2;
  localparam logic [EXTM_len-1:0] EXTM_SHIFT  = 3'd3;
  localparam logic [EXTM_len-1:0] EXTM_BRANCH = 3'd4;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: mode + raw immediate -> OUT_W operand.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; IMM_EXT_BRANCH_EN enables the BRANCH (sext << 2) mode.
module imm_ext_core
  import imm_ext_stage_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int SHAMT_LSB = 6,
  parameter int SHAMT_W   = 5
) (
  input  logic [EXTM_len-1:0] mode,
  input  logic [IN_W-1:0]     imm,
  output logic [OUT_W-1:0]    data
);

`ifdef IMM_EXT_BRANCH_EN
  logic [OUT_W-1:0] sext;
  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
`endif

  // Select the extended operand; unused codes fall back to zero extension
  always_comb begin
    data = {{(OUT_W-IN_W){1'b0}}, imm};
    case (mode)
      EXTM_SIGN:   data = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      EXTM_HIGH:   data = {imm, {(OUT_W-IN_W){1'b0}}};
      EXTM_SHIFT:  data = {{(OUT_W-SHAMT_W){1'b0}}, imm[SHAMT_LSB +: SHAMT_W]};
`ifdef IMM_EXT_BRANCH_EN
      // Top two bits of the sign-extended value are dropped by the shift
      EXTM_BRANCH: data = {sext[OUT_W-3:0], 2'b00};
`endif
      default:     data = {{(OUT_W-IN_W){1'b0}}, imm};
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage between decode and execute, with tag sideband.
// Latency: 1 cycle from input transfer to out_valid when main is empty or draining.
// Backpressure: main + skid registers; in_ready = !skid_valid (registered, no out_ready path).
// Build option: IMM_EXT_BRANCH_EN enables BRANCH mode in imm_ext_core.
module imm_ext_stage
  import imm_ext_stage_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int SHAMT_LSB = 6,
  parameter int SHAMT_W   = 5,
  parameter int TAG_W     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXTM_len-1:0] in_mode,
  input  logic [IN_W-1:0]     in_imm,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic [TAG_W-1:0]    out_tag
);

  logic [OUT_W-1:0] ext_data;
  logic             main_valid;
  logic [OUT_W-1:0] main_data;
  logic [TAG_W-1:0] main_tag;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             accept;
  logic             main_free;

  // Extension happens before the registers so only results are stored
  imm_ext_core #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .SHAMT_LSB (SHAMT_LSB),
    .SHAMT_W   (SHAMT_W)
  ) u_core (
    .mode (in_mode),
    .imm  (in_imm),
    .data (ext_data)
  );

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  // Main can take a new entry if it is empty or handing its entry downstream now
  assign main_free = ~main_valid | out_ready;

  // Main/skid update: reset beats flush, flush beats every transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Skid is older than anything upstream; in_ready was low so nothing is accepted
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_tag   <= skid_tag;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= ext_data;
        main_tag   <= in_tag;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= ext_data;
      skid_tag   <= in_tag;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_tag   = main_tag;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: extension modes, skid stall, flush, reset.
// Latency: inputs driven 1ns after posedge, outputs checked 1ns after the next posedge.
// Backpressure: out_ready is driven directly to exercise main/skid behaviour.
module tb_imm_ext_stage;
  import imm_ext_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [15:0] in_imm;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int tests = 0;
  int fails = 0;

  imm_ext_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_imm    (in_imm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] imm,
                       input logic [4:0] tg);
    in_valid = v;
    in_mode  = m;
    in_imm   = imm;
    in_tag   = tg;
  endtask

  logic [31:0] branch_exp;

  initial begin
`ifdef IMM_EXT_BRANCH_EN
    branch_exp = 32'hFFFF_FFFC;
`else
    branch_exp = 32'h0000_FFFF;
`endif
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, EXTM_ZERO, 16'h0, 5'd0);
    tick(); tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_data",  out_data,           32'd0);
    check("rst_out_tag",   {27'b0, out_tag},   32'd0);
    reset = 1'b0;

    // Back-to-back mode sweep with out_ready high: one result per cycle
    out_ready = 1'b1;
    drive(1'b1, EXTM_SIGN, 16'h8001, 5'd3); tick();
    check("sign_valid", {31'b0, out_valid}, 32'd1);
    check("sign_data",  out_data, 32'hFFFF_8001);
    check("sign_tag",   {27'b0, out_tag}, 32'd3);
    drive(1'b1, EXTM_HIGH, 16'h1234, 5'd4); tick();
    check("high_data",  out_data, 32'h1234_0000);
    check("high_tag",   {27'b0, out_tag}, 32'd4);
    drive(1'b1, EXTM_SHIFT, 16'h07C0, 5'd5); tick();
    check("shift_data", out_data, 32'h0000_001F);
    drive(1'b1, 3'd6, 16'hFFFF, 5'd6); tick();
    check("mode6_data", out_data, 32'h0000_FFFF);
    drive(1'b1, EXTM_BRANCH, 16'hFFFF, 5'd7); tick();
    check("branch_data", out_data, branch_exp);
    drive(1'b1, EXTM_ZERO, 16'h8001, 5'd8); tick();
    check("zero_data",  out_data, 32'h0000_8001);
    check("zero_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b0, EXTM_ZERO, 16'h0, 5'd0); tick();
    check("idle_valid", {31'b0, out_valid}, 32'd0);

    // Stall: A into main, B into skid, C held upstream
    out_ready = 1'b0;
    drive(1'b1, EXTM_ZERO, 16'h00AA, 5'd1); tick();
    check("stall_a_data",  out_data, 32'h0000_00AA);
    check("stall_a_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, EXTM_ZERO, 16'h00BB, 5'd2); tick();
    check("stall_b_ready", {31'b0, in_ready}, 32'd0);
    check("stall_hold_data", out_data, 32'h0000_00AA);
    drive(1'b1, EXTM_ZERO, 16'h00CC, 5'd3); tick();
    check("stall_c_ready", {31'b0, in_ready}, 32'd0);
    check("stall_hold_tag", {27'b0, out_tag}, 32'd1);
    out_ready = 1'b1; tick();
    check("drain_b_data",  out_data, 32'h0000_00BB);
    check("drain_b_tag",   {27'b0, out_tag}, 32'd2);
    check("drain_b_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("drain_c_data",  out_data, 32'h0000_00CC);
    check("drain_c_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b0, EXTM_ZERO, 16'h0, 5'd0); tick();
    check("drain_empty", {31'b0, out_valid}, 32'd0);

    // Flush with both registers full and a new entry offered
    out_ready = 1'b0;
    drive(1'b1, EXTM_ZERO, 16'h0011, 5'd5); tick();
    drive(1'b1, EXTM_ZERO, 16'h0022, 5'd6); tick();
    check("flush_pre_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, EXTM_ZERO, 16'h0033, 5'd7); tick();
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_ready", {31'b0, in_ready}, 32'd1);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, EXTM_ZERO, 16'h0, 5'd0); tick(); tick();
    check("flush_no_ghost", {31'b0, out_valid}, 32'd0);

    // Reset while main and skid are full and stalled
    out_ready = 1'b0;
    drive(1'b1, EXTM_SIGN, 16'hF00D, 5'd9); tick();
    drive(1'b1, EXTM_HIGH, 16'hBEEF, 5'd10); tick();
    check("rst2_pre_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b1; flush = 1'b1; tick();
    check("rst2_valid", {31'b0, out_valid}, 32'd0);
    check("rst2_data",  out_data, 32'd0);
    check("rst2_tag",   {27'b0, out_tag}, 32'd0);
    check("rst2_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, EXTM_ZERO, 16'h0, 5'd0); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
